// File: rtl/mmc1_pkg.sv
// Shared definitions for the MMC1 mapper controller: mirroring codes,
// PRG banking modes, serial-register select codes and the control reset value.
package mmc1_pkg;

  // Nametable mirroring, control[1:0]
  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'd0,  // single screen, lower bank
    MIR_ONE_HI = 2'd1,  // single screen, upper bank
    MIR_VERT   = 2'd2,  // vertical mirroring, VRAM A10 = PPU A10
    MIR_HORZ   = 2'd3   // horizontal mirroring, VRAM A10 = PPU A11
  } mirror_t;

  // PRG banking mode, control[3:2]
  typedef enum logic [1:0] {
    PRG_MODE_32K_0     = 2'd0,  // 32 KB switchable, low bank bit ignored
    PRG_MODE_32K_1     = 2'd1,  // same as mode 0
    PRG_MODE_FIX_FIRST = 2'd2,  // $8000 fixed to bank 0, $C000 switchable
    PRG_MODE_FIX_LAST  = 2'd3   // $8000 switchable, $C000 fixed to last bank
  } prg_mode_t;

  // Internal register addressed by CPU A14..A13 on the fifth serial write
  typedef enum logic [1:0] {
    SEL_CONTROL = 2'd0,
    SEL_CHR0    = 2'd1,
    SEL_CHR1    = 2'd2,
    SEL_PRG     = 2'd3
  } reg_sel_t;

  // Control register layout, MSB first
  typedef struct packed {
    logic      chr_4k;    // 0: one 8 KB CHR bank, 1: two 4 KB banks
    prg_mode_t prg_mode;
    mirror_t   mirror;
  } ctrl_t;

  // Reset value of the control register; also OR-ed in on a reset write
  localparam logic [4:0] CTRL_RESET = 5'b01100;

  // Serial sequence length: four shifts, the fifth write loads
  localparam logic [2:0] LAST_SHIFT_COUNT = 3'd4;

endpackage

// File: rtl/mmc1_serial_load.sv
// MMC1 serial port: detects CPU write edges, optionally filters writes that
// follow an accepted one too closely, and assembles five single-bit writes
// into a 5-bit register load. A write with bit 7 set restarts the sequence.
// Optional feature macro: MMC1_WRITE_FILTER_EN (builds the write gap filter).
module mmc1_serial_load
  import mmc1_pkg::*;
#(
  parameter int MIN_WR_GAP = 12
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       prg_nce_in,
  input  logic       prg_r_nw_in,
  input  logic [1:0] sel_in,
  input  logic       d_bit,
  input  logic       reset_bit,
  output logic       reset_wr,
  output logic       load,
  output reg_sel_t   sel,
  output logic [4:0] data
);

  logic       strobe;
  logic       wr_edge;
  logic       accept;
  logic       wr_q  = 1'b0;
  logic [4:0] shift = 5'b0;
  logic [2:0] count = 3'b0;

  assign strobe  = ~prg_r_nw_in & ~prg_nce_in;
  assign wr_edge = strobe & ~wr_q;

`ifdef MMC1_WRITE_FILTER_EN
  localparam int GAP_W = (MIN_WR_GAP < 2) ? 1 : $clog2(MIN_WR_GAP + 1);

  logic [GAP_W-1:0] gap = '0;

  assign accept = wr_edge & (gap == '0);

  // Gap counter: reload on every accepted write, then count down to idle
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      gap <= '0;
    end else if (accept) begin
      gap <= GAP_W'(MIN_WR_GAP);
    end else if (gap != '0) begin
      gap <= gap - 1'b1;
    end
  end
`else
  // Without the filter every edge is taken; the gap parameter has no effect
  logic unused_gap;
  assign unused_gap = ^MIN_WR_GAP;

  assign accept = wr_edge;
`endif

  // Edge register, shift register and bit count
  always_ff @(posedge clk_sys) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_q  <= 1'b0;
      shift <= 5'b0;
      count <= 3'b0;
    end else begin
      wr_q <= strobe;
      if (accept) begin
        if (reset_bit || count == LAST_SHIFT_COUNT) begin
          shift <= 5'b0;
          count <= 3'b0;
        end else begin
          shift <= {d_bit, shift[4:1]};
          count <= count + 3'd1;
        end
      end
    end
  end

  // The load is decoded combinationally from the accepting edge so the target
  // register updates on that same clock edge.
  assign reset_wr = accept & reset_bit;
  assign load     = accept & ~reset_bit & (count == LAST_SHIFT_COUNT);
  assign sel      = reg_sel_t'(sel_in);
  assign data     = {d_bit, shift[4:1]};

  // shift[0] falls out on the fifth write and is never part of the loaded value
  logic unused_shift;
  assign unused_shift = shift[0];

endmodule

// File: rtl/mmc1_ctrl.sv
// MMC1 mapper controller top: holds the control, CHR and PRG bank registers
// loaded through the serial port and maps CPU/PPU addresses onto PRG-ROM,
// CHR memory and the console nametable RAM.
// Optional feature macro: MMC1_WRITE_FILTER_EN (write gap filter, see
// mmc1_serial_load).
module mmc1_ctrl
  import mmc1_pkg::*;
#(
  parameter int MIN_WR_GAP = 12
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        prg_nce_in,
  input  logic [14:0] prg_a_in,
  input  logic        prg_r_nw_in,
  input  logic [7:0]  prg_d_in,
  input  logic [13:0] chr_a_in,
  output logic [17:0] prg_rom_a_out,
  output logic [16:0] chr_mem_a_out,
  output logic        ciram_a10_out,
  output logic        ciram_nce_out
);

  logic       reset_wr;
  logic       load;
  reg_sel_t   load_sel;
  logic [4:0] load_data;

  ctrl_t      control = CTRL_RESET;
  logic [4:0] chr0    = 5'b0;
  logic [4:0] chr1    = 5'b0;
  logic [4:0] prg     = 5'b0;

  mmc1_serial_load #(
    .MIN_WR_GAP (MIN_WR_GAP)
  ) u_serial (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .prg_nce_in  (prg_nce_in),
    .prg_r_nw_in (prg_r_nw_in),
    .sel_in      (prg_a_in[14:13]),
    .d_bit       (prg_d_in[0]),
    .reset_bit   (prg_d_in[7]),
    .reset_wr    (reset_wr),
    .load        (load),
    .sel         (load_sel),
    .data        (load_data)
  );

  // Bank registers: reset write forces fixed-last PRG mode, fifth write loads
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      control <= CTRL_RESET;
      chr0    <= 5'b0;
      chr1    <= 5'b0;
      prg     <= 5'b0;
    end else if (reset_wr) begin
      control <= ctrl_t'(control | CTRL_RESET);
    end else if (load) begin
      unique case (load_sel)
        SEL_CONTROL: control <= ctrl_t'(load_data);
        SEL_CHR0:    chr0    <= load_data;
        SEL_CHR1:    chr1    <= load_data;
        SEL_PRG:     prg     <= load_data;
      endcase
    end
  end

  // PRG-ROM address: 32 KB mode or 16 KB mode with one half fixed
  always_comb begin
    // NOTE: default assignment first so no path through the block can
    // leave the output unassigned and infer a latch.
    prg_rom_a_out = '0;
    unique case (control.prg_mode)
      PRG_MODE_32K_0, PRG_MODE_32K_1:
        prg_rom_a_out = {prg[3:1], prg_a_in};
      PRG_MODE_FIX_FIRST:
        prg_rom_a_out = prg_a_in[14] ? {prg[3:0], prg_a_in[13:0]}
                                     : {4'b0000, prg_a_in[13:0]};
      PRG_MODE_FIX_LAST:
        prg_rom_a_out = prg_a_in[14] ? {4'b1111, prg_a_in[13:0]}
                                     : {prg[3:0], prg_a_in[13:0]};
    endcase
  end

  // CHR address: one 8 KB bank or two independent 4 KB banks
  always_comb begin
    chr_mem_a_out = '0;
    if (!control.chr_4k) begin
      chr_mem_a_out = {chr0[4:1], chr_a_in[12:0]};
    end else if (!chr_a_in[12]) begin
      chr_mem_a_out = {chr0, chr_a_in[11:0]};
    end else begin
      chr_mem_a_out = {chr1, chr_a_in[11:0]};
    end
  end

  // Nametable RAM A10 from the mirroring mode
  always_comb begin
    ciram_a10_out = 1'b0;
    unique case (control.mirror)
      MIR_ONE_LO: ciram_a10_out = 1'b0;
      MIR_ONE_HI: ciram_a10_out = 1'b1;
      MIR_VERT:   ciram_a10_out = chr_a_in[10];
      MIR_HORZ:   ciram_a10_out = chr_a_in[11];
    endcase
  end

  // Nametable RAM is selected for PPU $2000-$3FFF
  assign ciram_nce_out = ~chr_a_in[13];

  // Data bits 6..1 carry no meaning; prg[4] (PRG-RAM enable) is not mapped here
  logic unused_bits;
  assign unused_bits = ^{prg_d_in[6:1], prg[4]};

endmodule

// File: tb/tb_mmc1_ctrl.sv
// Self-checking bench for mmc1_ctrl. A behavioural model tracks the mapper
// registers as integers and the pending serial bits as a queue, and computes
// expected bus addresses with plain arithmetic.
module tb_mmc1_ctrl;

  localparam int GAP = 12;
  localparam int SP  = GAP + 2;  // idle cycles that guarantee the next write is taken

`ifdef MMC1_WRITE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        prg_nce_in;
  logic [14:0] prg_a_in;
  logic        prg_r_nw_in;
  logic [7:0]  prg_d_in;
  logic [13:0] chr_a_in;
  logic [17:0] prg_rom_a_out;
  logic [16:0] chr_mem_a_out;
  logic        ciram_a10_out;
  logic        ciram_nce_out;

  mmc1_ctrl #(.MIN_WR_GAP(GAP)) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .prg_nce_in    (prg_nce_in),
    .prg_a_in      (prg_a_in),
    .prg_r_nw_in   (prg_r_nw_in),
    .prg_d_in      (prg_d_in),
    .chr_a_in      (chr_a_in),
    .prg_rom_a_out (prg_rom_a_out),
    .chr_mem_a_out (chr_mem_a_out),
    .ciram_a10_out (ciram_a10_out),
    .ciram_nce_out (ciram_nce_out)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int now    = 0;  // number of rising edges so far

  // Reference model state
  int m_ctrl, m_chr0, m_chr1, m_prg;
  int m_bits[$];
  int m_last_accept;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    now++;
    @(negedge clk_sys);
  endtask

  function automatic void model_reset();
    m_ctrl = 12;
    m_chr0 = 0;
    m_chr1 = 0;
    m_prg  = 0;
    m_bits.delete();
    m_last_accept = -1000;
  endfunction

  // A write edge seen at rising edge number 'now'
  function automatic void model_edge(input int a, input int d);
    int v;
    if (FILTER && (now - m_last_accept) <= GAP) return;
    m_last_accept = now;
    if ((d / 128) % 2 == 1) begin
      m_bits.delete();
      m_ctrl = m_ctrl | 12;
      return;
    end
    m_bits.push_back(d % 2);
    if (m_bits.size() == 5) begin
      v = 0;
      for (int i = 0; i < 5; i++) v += m_bits[i] * (1 << i);
      case ((a / 8192) % 4)
        0: m_ctrl = v;
        1: m_chr0 = v;
        2: m_chr1 = v;
        default: m_prg = v;
      endcase
      m_bits.delete();
    end
  endfunction

  function automatic int exp_prg(input int a);
    int mode = (m_ctrl / 4) % 4;
    int low  = a % 16384;
    int a14  = (a / 16384) % 2;
    case (mode)
      0, 1:    return ((m_prg / 2) % 8) * 32768 + (a % 32768);
      2:       return a14 ? (m_prg % 16) * 16384 + low : low;
      default: return a14 ? 15 * 16384 + low : (m_prg % 16) * 16384 + low;
    endcase
  endfunction

  function automatic int exp_chr(input int ca);
    if ((m_ctrl / 16) % 2 == 0) return ((m_chr0 / 2) % 16) * 8192 + ca % 8192;
    if ((ca / 4096) % 2 == 1)   return m_chr1 * 4096 + ca % 4096;
    return m_chr0 * 4096 + ca % 4096;
  endfunction

  function automatic int exp_a10(input int ca);
    case (m_ctrl % 4)
      0:       return 0;
      1:       return 1;
      2:       return (ca / 1024) % 2;
      default: return (ca / 2048) % 2;
    endcase
  endfunction

  task automatic check_map(input string tag, input int a, input int ca);
    prg_a_in = 15'(a);
    chr_a_in = 14'(ca);
    #1;
    check({tag, ".prg"},  32'(prg_rom_a_out), exp_prg(a));
    check({tag, ".chr"},  32'(chr_mem_a_out), exp_chr(ca));
    check({tag, ".a10"},  32'(ciram_a10_out), exp_a10(ca));
    check({tag, ".nce"},  32'(ciram_nce_out), 32'(((ca / 8192) % 2) == 0));
  endtask

  task automatic check_rand(input string tag);
    check_map(tag, int'($urandom_range(0, 32767)), int'($urandom_range(0, 16383)));
  endtask

  task automatic cpu_write(input int a, input int d, input int idle);
    prg_a_in    = 15'(a);
    prg_d_in    = 8'(d);
    prg_nce_in  = 1'b0;
    prg_r_nw_in = 1'b0;
    tick();
    model_edge(a, d);
    prg_nce_in  = 1'b1;
    prg_r_nw_in = 1'b1;
    repeat (idle) tick();
  endtask

  // Five serial writes of v, LSB first, with random don't-care bits 6..1
  task automatic write_reg(input int a, input int v);
    for (int i = 0; i < 5; i++)
      cpu_write(a, ((v >> i) & 1) | int'($urandom_range(0, 63) << 1), SP);
  endtask

  initial begin
    int bits5[5];
    int v;

    rst         = 1'b1;
    prg_nce_in  = 1'b1;
    prg_r_nw_in = 1'b1;
    prg_a_in    = '0;
    prg_d_in    = '0;
    chr_a_in    = '0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();

    // Reset state: last PRG bank fixed at $C000, bank 0 at $8000
    check_map("reset_hi", 15'h4321, 14'h2400);
    check("reset_last_bank", 32'(prg_rom_a_out[17:14]), 32'hF);
    check_map("reset_lo", 15'h1234, 14'h0ABC);
    check("reset_bank0", 32'(prg_rom_a_out[17:14]), 32'h0);

    // Serial load of 00101 into PRG at $E000, visible one cycle after write 5
    bits5 = '{1, 0, 1, 0, 0};
    for (int i = 0; i < 4; i++) cpu_write(15'h6000, bits5[i], SP);
    cpu_write(15'h6000, bits5[4], 0);
    prg_a_in = 15'h0123;
    #1;
    check("serial_prg_bank", 32'(prg_rom_a_out[17:14]), 32'h5);
    check_map("serial_map", 15'h0123, 14'h1555);
    repeat (SP) tick();

    // Mirroring: control = 00011 (horizontal)
    write_reg(15'h0000, 5'b00011);
    chr_a_in = 14'h2800;
    #1;
    check("mirror_2800", 32'(ciram_a10_out), 32'd1);
    chr_a_in = 14'h2400;
    #1;
    check("mirror_2400", 32'(ciram_a10_out), 32'd0);
    check_map("mirror_map", 15'h5555, 14'h2C00);

    // Reset write after two bits: PRG mode forced to 3, count cleared
    cpu_write(15'h6000, 1, SP);
    cpu_write(15'h6000, 1, SP);
    cpu_write(15'h6000, 8'h80, SP);
    prg_a_in = 15'h4000;
    #1;
    check("rstwr_last_bank", 32'(prg_rom_a_out[17:14]), 32'hF);
    check_map("rstwr_map", 15'h0777, 14'h2800);
    write_reg(15'h2000, 5'b10110);
    check_map("rstwr_fresh", 15'h2222, 14'h0F0F);
    check_rand("rstwr_rand");

    // Gap filter: second edge only 3 cycles after the first
    cpu_write(15'h6000, 1, 2);
    cpu_write(15'h6000, 1, SP);
    for (int i = 0; i < 3; i++) cpu_write(15'h6000, 0, SP);
    check_map("gap_after3", 15'h1111, 14'h0000);
    cpu_write(15'h6000, 0, SP);
    check_map("gap_after4", 15'h2468, 14'h1000);
    cpu_write(15'h6000, 8'h80, SP);

    // Held strobe: 20 cycles low gives exactly one edge
    prg_a_in    = 15'h6000;
    prg_d_in    = 8'h01;
    prg_nce_in  = 1'b0;
    prg_r_nw_in = 1'b0;
    tick();
    model_edge(15'h6000, 1);
    repeat (19) tick();
    prg_nce_in  = 1'b1;
    prg_r_nw_in = 1'b1;
    repeat (SP) tick();
    for (int i = 0; i < 4; i++) cpu_write(15'h6000, 0, SP);
    check_map("held_strobe", 15'h0042, 14'h0042);
    check("held_prg_bank", 32'(prg_rom_a_out[17:14]), 32'h1);

    // Reset mid-load, with a write edge at the same clock as rst
    for (int i = 0; i < 3; i++) cpu_write(15'h6000, 1, SP);
    rst         = 1'b1;
    prg_a_in    = 15'h6000;
    prg_d_in    = 8'h01;
    prg_nce_in  = 1'b0;
    prg_r_nw_in = 1'b0;
    tick();
    rst         = 1'b0;
    prg_nce_in  = 1'b1;
    prg_r_nw_in = 1'b1;
    model_reset();
    check_map("midrst_hi", 15'h7FFF, 14'h2400);
    check("midrst_last_bank", 32'(prg_rom_a_out[17:14]), 32'hF);
    check_map("midrst_lo", 15'h0001, 14'h1FFF);
    repeat (SP) tick();
    write_reg(15'h6000, 5'b01001);
    check_map("midrst_fresh", 15'h0100, 14'h0100);
    check("midrst_fresh_bank", 32'(prg_rom_a_out[17:14]), 32'h9);

    // Random register traffic with occasional close writes and reset writes
    for (int it = 0; it < 30; it++) begin
      v = int'($urandom_range(0, 31));
      for (int i = 0; i < 5; i++) begin
        cpu_write(int'($urandom_range(0, 32767)),
                  ((v >> i) & 1) | int'($urandom_range(0, 63) << 1),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : SP);
      end
      if ($urandom_range(0, 9) == 0) cpu_write(15'h0000, 8'h80, SP);
      check_rand("rand_a");
      check_rand("rand_b");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
